// File: rtl/fifo_stream_pkg.sv
// Shared definitions for the fifo drain stream stage.
//   BUSW_DEF  - default data width, matching the fifo bus width
//   SKID_DEF  - default skid buffer depth
//   CNT_W_DEF - default transfer counter width
//   data_t    - one data word at the default width
//   ptr_width - skid buffer pointer width, $clog2(SKID), never below 1
//   occ_width - width needed to hold an occupancy of 0..SKID
package fifo_stream_pkg;

  localparam int BUSW_DEF  = 32;
  localparam int SKID_DEF  = 2;
  localparam int CNT_W_DEF = 16;

  typedef logic [BUSW_DEF-1:0] data_t;

  function automatic int ptr_width(input int skid);
    return (skid > 1) ? $clog2(skid) : 1;
  endfunction

  function automatic int occ_width(input int skid);
    return $clog2(skid + 1);
  endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Small circular register file that absorbs the fifo read latency.
// Ports:
//   clk     in   rising-edge clock
//   rst     in   asynchronous active-low reset, clears contents and pointers
//   wr_en   in   store wr_data at the write pointer
//   wr_data in   word to store
//   rd_en   in   retire the word at the read pointer (only when occ != 0)
//   rd_data out  word at the read pointer
//   occ     out  number of stored words, 0..SKID
module fifo_skid_buf
  import fifo_stream_pkg::*;
#(
  parameter int BUSW = BUSW_DEF,
  parameter int SKID = SKID_DEF,
  localparam int PTR_W = ptr_width(SKID),
  localparam int OCC_W = occ_width(SKID)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [BUSW-1:0]  wr_data,
  input  logic             rd_en,
  output logic [BUSW-1:0]  rd_data,
  output logic [OCC_W-1:0] occ
);

  logic [BUSW-1:0]  mem [SKID];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Pointers wrap explicitly so depths that are not a power of two work.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(SKID - 1)) ? '0 : p + 1'b1;
  endfunction

  // Storage, pointers and occupancy. Reset clears the contents too so no
  // stale word can surface on rd_data after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SKID; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (rd_en) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      if (wr_en && !rd_en) begin
        occ <= occ + 1'b1;
      end else if (!wr_en && rd_en) begin
        occ <= occ - 1'b1;
      end
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/fifo_pull_stage.sv
// Drain stage for the fifo: pulls words with pull/empty/dataout and presents
// them on a valid/ready stream, sustaining one word per clock.
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-low reset
//   empty     in   fifo empty flag (combinational from the fifo)
//   dataout   in   fifo read data, valid the clock after pull
//   pull      out  fifo read strobe
//   out_valid out  stream word available
//   out_ready in   consumer accepts the word
//   out_data  out  stream word
//   xfer_cnt  out  number of accepted stream words, wraps
module fifo_pull_stage
  import fifo_stream_pkg::*;
#(
  parameter int BUSW  = BUSW_DEF,
  parameter int SKID  = SKID_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             empty,
  input  logic [BUSW-1:0]  dataout,
  output logic             pull,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BUSW-1:0]  out_data,
  output logic [CNT_W-1:0] xfer_cnt
);

  localparam int OCC_W = occ_width(SKID);
  localparam int SUM_W = OCC_W + 1;

  logic             inflight;
  logic             pop;
  logic [OCC_W-1:0] occ;
  logic [SUM_W-1:0] projected;

  assign out_valid = (occ != '0);
  assign pop       = out_valid & out_ready;

  // Occupancy once the in-flight word lands and this clock's pop retires.
  // Crediting the pop is what keeps a 2-entry buffer at full throughput.
  // pop implies occ >= 1, so the subtraction never underflows.
  assign projected = SUM_W'(occ) + SUM_W'(inflight) - SUM_W'(pop);
  assign pull      = rst & ~empty & (projected < SUM_W'(SKID));

  // Registered copy of pull: the fifo word arrives on dataout one clock later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight <= 1'b0;
    end else begin
      inflight <= pull;
    end
  end

  // Accepted-word counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xfer_cnt <= '0;
    end else if (pop) begin
      xfer_cnt <= xfer_cnt + 1'b1;
    end
  end

  fifo_skid_buf #(
    .BUSW (BUSW),
    .SKID (SKID)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (inflight),
    .wr_data (dataout),
    .rd_en   (pop),
    .rd_data (out_data),
    .occ     (occ)
  );

  // The pull rule must keep a landing word from ever meeting a full buffer.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
                                  !(inflight && (occ == OCC_W'(SKID))));

  // An empty fifo is never read.
  a_no_empty_pull: assert property (@(posedge clk) disable iff (!rst)
                                    !(pull && empty));

endmodule

// File: tb/tb_fifo_pull_stage.sv
// Directed bench for fifo_pull_stage. A behavioural fifo feeds two copies of
// the stage (16-bit and 4-bit transfer counters) that share every input.
module tb_fifo_pull_stage;
  import fifo_stream_pkg::*;

  logic       clk       = 1'b0;
  logic       rst       = 1'b0;
  logic       out_ready = 1'b1;
  logic       empty;
  data_t      dataout   = '0;

  logic       pull;
  logic       out_valid;
  data_t      out_data;
  logic [15:0] xfer_cnt;

  logic       pull4;
  logic       out_valid4;
  data_t      out_data4;
  logic [3:0] xfer_cnt4;

  data_t fmem [0:127];
  int    fwr   = 0;
  int    frd   = 0;
  int    total = 0;
  int    bad   = 0;

  always #5 clk = ~clk;

  // Behavioural fifo: combinational empty, one-clock read latency.
  assign empty = (fwr == frd);

  always @(posedge clk) begin
    if (pull) begin
      dataout <= fmem[frd];
      frd     <= frd + 1;
    end
  end

  fifo_pull_stage #(.BUSW(32), .SKID(2), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .empty     (empty),
    .dataout   (dataout),
    .pull      (pull),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .xfer_cnt  (xfer_cnt)
  );

  fifo_pull_stage #(.BUSW(32), .SKID(2), .CNT_W(4)) dut_w4 (
    .clk       (clk),
    .rst       (rst),
    .empty     (empty),
    .dataout   (dataout),
    .pull      (pull4),
    .out_valid (out_valid4),
    .out_ready (out_ready),
    .out_data  (out_data4),
    .xfer_cnt  (xfer_cnt4)
  );

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive the control inputs and let combinational outputs settle.
  task automatic applyStimulus(input logic rst_v, input logic ready_v);
    rst       = rst_v;
    out_ready = ready_v;
    #1;
  endtask

  // Queue one word in the behavioural fifo.
  task automatic pushWord(input data_t w);
    fmem[fwr] = w;
    fwr++;
  endtask

  // One clock of reset, keeping out_ready as it is.
  task automatic resetPulse();
    @(negedge clk);
    applyStimulus(1'b0, out_ready);
    checkOutput("rst_pulse_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    applyStimulus(1'b1, out_ready);
  endtask

  initial begin
    int pulls;
    int idx;
    int p_first, p_last, p_cnt;
    int v_first, v_last, v_cnt;

    $display("[TB] start");

    // Reset held with a word waiting and the consumer ready.
    pushWord(32'hDEADBEEF);
    #1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("t1_pull", 64'(pull), 64'd0);
      checkOutput("t1_valid", 64'(out_valid), 64'd0);
      checkOutput("t1_cnt", 64'(xfer_cnt), 64'd0);
    end
    checkOutput("t1_data", 64'(out_data), 64'd0);

    // Single word: first pull on release, word appears two clocks later.
    applyStimulus(1'b1, 1'b1);
    checkOutput("t2_first_pull", 64'(pull), 64'd1);
    @(negedge clk);
    checkOutput("t2_pull_done", 64'(pull), 64'd0);
    checkOutput("t2_valid_early", 64'(out_valid), 64'd0);
    @(negedge clk);
    checkOutput("t2_valid", 64'(out_valid), 64'd1);
    checkOutput("t2_data", 64'(out_data), 64'hDEADBEEF);
    checkOutput("t2_cnt_before", 64'(xfer_cnt), 64'd0);
    @(negedge clk);
    checkOutput("t2_valid_gone", 64'(out_valid), 64'd0);
    checkOutput("t2_cnt", 64'(xfer_cnt), 64'd1);

    // Backpressure: five words queued, consumer stalled.
    resetPulse();
    applyStimulus(1'b1, 1'b0);
    for (int w = 1; w <= 5; w++) pushWord(data_t'(w));
    #1;
    pulls = 0;
    for (int s = 0; s < 7; s++) begin
      if (pull) pulls++;
      @(negedge clk);
    end
    checkOutput("t3_pull_count", 64'(pulls), 64'd2);
    checkOutput("t3_pull_stop", 64'(pull), 64'd0);
    checkOutput("t3_valid_held", 64'(out_valid), 64'd1);
    checkOutput("t3_data_held", 64'(out_data), 64'd1);
    applyStimulus(1'b1, 1'b1);
    idx = 0;
    for (int s = 0; s < 20 && idx < 5; s++) begin
      if (out_valid) begin
        checkOutput("t3_order", 64'(out_data), 64'(idx + 1));
        idx++;
      end
      if (idx < 5) @(negedge clk);
    end
    checkOutput("t3_drained", 64'(idx), 64'd5);
    @(negedge clk);
    checkOutput("t3_valid_end", 64'(out_valid), 64'd0);
    checkOutput("t3_cnt", 64'(xfer_cnt), 64'd5);

    // Streaming: 31 words with the consumer always ready.
    resetPulse();
    for (int w = 0; w < 31; w++) pushWord(data_t'(32'h100 + w));
    #1;
    p_first = -1; p_last = -1; p_cnt = 0;
    v_first = -1; v_last = -1; v_cnt = 0;
    for (int s = 0; s < 40; s++) begin
      if (pull) begin
        if (p_first < 0) p_first = s;
        p_last = s;
        p_cnt++;
      end
      if (out_valid) begin
        checkOutput("t4_data", 64'(out_data), 64'(32'h100 + v_cnt));
        if (v_first < 0) v_first = s;
        v_last = s;
        v_cnt++;
      end
      @(negedge clk);
    end
    checkOutput("t4_pull_count", 64'(p_cnt), 64'd31);
    checkOutput("t4_pull_span", 64'(p_last - p_first + 1), 64'd31);
    checkOutput("t4_valid_count", 64'(v_cnt), 64'd31);
    checkOutput("t4_valid_span", 64'(v_last - v_first + 1), 64'd31);
    checkOutput("t4_latency", 64'(v_first - p_first), 64'd2);
    checkOutput("t4_cnt", 64'(xfer_cnt), 64'd31);

    // Reset while a word is in flight and one word is buffered.
    applyStimulus(1'b1, 1'b0);
    pushWord(32'hAAAA0001);
    pushWord(32'hAAAA0002);
    pushWord(32'hAAAA0003);
    #1;
    checkOutput("t5_pull_a", 64'(pull), 64'd1);
    @(negedge clk);
    checkOutput("t5_pull_b", 64'(pull), 64'd1);
    @(negedge clk);
    checkOutput("t5_pre_valid", 64'(out_valid), 64'd1);
    checkOutput("t5_pre_data", 64'(out_data), 64'hAAAA0001);
    checkOutput("t5_pre_pull", 64'(pull), 64'd0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("t5_rst_valid", 64'(out_valid), 64'd0);
    checkOutput("t5_rst_data", 64'(out_data), 64'd0);
    checkOutput("t5_rst_pull", 64'(pull), 64'd0);
    @(negedge clk);
    checkOutput("t5_rst_pull_hold", 64'(pull), 64'd0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("t5_new_pull", 64'(pull), 64'd1);
    checkOutput("t5_valid_0", 64'(out_valid), 64'd0);
    @(negedge clk);
    checkOutput("t5_valid_1", 64'(out_valid), 64'd0);
    @(negedge clk);
    checkOutput("t5_valid_new", 64'(out_valid), 64'd1);
    checkOutput("t5_data_new", 64'(out_data), 64'hAAAA0003);
    @(negedge clk);
    checkOutput("t5_valid_end", 64'(out_valid), 64'd0);
    checkOutput("t5_cnt", 64'(xfer_cnt), 64'd1);

    // Counter wrap: 17 transfers on both counter widths.
    resetPulse();
    for (int w = 0; w < 17; w++) pushWord(data_t'(32'h200 + w));
    #1;
    repeat (30) @(negedge clk);
    checkOutput("t6_cnt16", 64'(xfer_cnt), 64'd17);
    checkOutput("t6_cnt4_wrap", 64'(xfer_cnt4), 64'd1);
    checkOutput("t6_valid_end", 64'(out_valid4), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
